// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood mode sequencer.
// Turns debounced front-panel inputs into the operating mode. Drives the
// timekeeping controls (power_on, state, set_all_times), the fan level and a
// seconds countdown for the display.
// Optional feature: define HOOD_HURRICANE_LOCK_EN to add the hurricane lock.
// With the lock, level 3 can be entered only once per power-on.

module hood_mode_ctrl #(
    parameter int unsigned TICK_HZ      = 100,
    parameter int unsigned LONG_PRESS_S = 3,
    parameter int unsigned HURRICANE_S  = 60,
    parameter int unsigned CLEAN_S      = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_100hz,
    input  logic       btn_power,
    input  logic       btn_menu,
    input  logic       btn_l1,
    input  logic       btn_l2,
    input  logic       btn_l3,
    input  logic       btn_clean,
    input  logic       btn_set,
    output logic       power_on,
    output logic [1:0] state,
    output logic [1:0] set_all_times,
    output logic [1:0] fan_level,
    output logic [2:0] mode,
    output logic [7:0] countdown
);

    localparam int unsigned LP_TICKS = LONG_PRESS_S * TICK_HZ;
    localparam int unsigned SUB_W    = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
    localparam int unsigned LP_W     = $clog2(LP_TICKS + 1);
    localparam int unsigned CD_W     = 8;

    localparam logic [2:0] MODE_OFF        = 3'd0;
    localparam logic [2:0] MODE_STANDBY    = 3'd1;
    localparam logic [2:0] MODE_EXTRACT    = 3'd2;
    localparam logic [2:0] MODE_HURRICANE  = 3'd3;
    localparam logic [2:0] MODE_DRAIN      = 3'd4;
    localparam logic [2:0] MODE_CLEAN      = 3'd5;
    localparam logic [2:0] MODE_SET_TIME   = 3'd6;
    localparam logic [2:0] MODE_SET_REMIND = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WORK  = 2'b10;
    localparam logic [1:0] ST_CLEAN = 2'b11;

    localparam logic [1:0] SAT_NONE   = 2'b00;
    localparam logic [1:0] SAT_TIME   = 2'b01;
    localparam logic [1:0] SAT_REMIND = 2'b10;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK_HZ - 1);
    localparam logic [LP_W-1:0]  LP_MAX   = LP_W'(LP_TICKS);
    localparam logic [CD_W-1:0]  CD_HURR  = CD_W'(HURRICANE_S);
    localparam logic [CD_W-1:0]  CD_CLEAN = CD_W'(CLEAN_S);

    logic [SUB_W-1:0] sub_cnt;
    logic [LP_W-1:0]  lp_cnt;
    logic             lp_done;
    logic             lp_evt;
    logic             sub_wrap;
    logic             timed;
    logic             expire;
    logic             l3_ok;
    logic             enter;

    logic [2:0]       mode_nxt;
    logic [1:0]       fan_nxt;
    logic [CD_W-1:0]  cd_nxt;
    logic             pon_nxt;
    logic [1:0]       state_nxt;
    logic [1:0]       sat_nxt;

    // One-second boundary and countdown expiry.
    assign sub_wrap = tick_100hz && (sub_cnt == SUB_LAST);
    assign timed    = (mode == MODE_HURRICANE) || (mode == MODE_DRAIN) ||
                      (mode == MODE_CLEAN);
    assign expire   = timed && (countdown == '0);

    // A long press fires once per hold, once the counter sits at its threshold.
    assign lp_evt = btn_power && (lp_cnt == LP_MAX) && !lp_done;

    // Long-press tick counter, saturating at the threshold, clears on release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lp_cnt <= '0;
        end else if (!btn_power) begin
            lp_cnt <= '0;
        end else if (tick_100hz && (lp_cnt != LP_MAX)) begin
            lp_cnt <= lp_cnt + LP_W'(1);
        end
    end

    // Remembers that the current hold has already toggled power.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lp_done <= 1'b0;
        end else if (!btn_power) begin
            lp_done <= 1'b0;
        end else if (lp_evt) begin
            lp_done <= 1'b1;
        end
    end

`ifdef HOOD_HURRICANE_LOCK_EN
    logic hurr_lock;

    // The hurricane lock is set on entry to level 3 and cleared only by power-off.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hurr_lock <= 1'b0;
        end else if (enter && (mode_nxt == MODE_OFF)) begin
            hurr_lock <= 1'b0;
        end else if (enter && (mode_nxt == MODE_HURRICANE)) begin
            hurr_lock <= 1'b1;
        end
    end

    assign l3_ok = !hurr_lock;
`else
    assign l3_ok = 1'b1;
`endif

    // Sub-second divider. Cleared on mode entry so the first second is always full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sub_cnt <= '0;
        end else if (enter) begin
            sub_cnt <= '0;
        end else if (tick_100hz) begin
            sub_cnt <= sub_wrap ? '0 : sub_cnt + SUB_W'(1);
        end
    end

    // Next mode, fan level and countdown, plus decoded outputs for the new mode.
    always_comb begin
        mode_nxt  = mode;
        fan_nxt   = fan_level;
        enter     = 1'b0;
        cd_nxt    = countdown;
        pon_nxt   = 1'b0;
        state_nxt = ST_IDLE;
        sat_nxt   = SAT_NONE;

        if (lp_evt) begin
            mode_nxt = (mode == MODE_OFF) ? MODE_STANDBY : MODE_OFF;
            enter    = 1'b1;
        end else if (expire) begin
            enter = 1'b1;
            if (mode == MODE_HURRICANE) begin
                mode_nxt = MODE_EXTRACT;
                fan_nxt  = 2'd2;
            end else begin
                mode_nxt = MODE_STANDBY;
            end
        end else begin
            case (mode)
                MODE_STANDBY: begin
                    if (btn_clean) begin
                        mode_nxt = MODE_CLEAN;
                        enter    = 1'b1;
                    end else if (btn_l3 && l3_ok) begin
                        mode_nxt = MODE_HURRICANE;
                        enter    = 1'b1;
                    end else if (btn_l2) begin
                        mode_nxt = MODE_EXTRACT;
                        fan_nxt  = 2'd2;
                        enter    = 1'b1;
                    end else if (btn_l1) begin
                        mode_nxt = MODE_EXTRACT;
                        fan_nxt  = 2'd1;
                        enter    = 1'b1;
                    end else if (btn_set) begin
                        mode_nxt = MODE_SET_TIME;
                        enter    = 1'b1;
                    end
                end
                MODE_EXTRACT: begin
                    // A level change keeps the mode, so it does not restart the divider.
                    if (btn_menu) begin
                        mode_nxt = MODE_STANDBY;
                        enter    = 1'b1;
                    end else if (btn_l2) begin
                        fan_nxt = 2'd2;
                    end else if (btn_l1) begin
                        fan_nxt = 2'd1;
                    end
                end
                MODE_HURRICANE: begin
                    if (btn_menu) begin
                        mode_nxt = MODE_DRAIN;
                        enter    = 1'b1;
                    end
                end
                MODE_SET_TIME: begin
                    if (btn_menu) begin
                        mode_nxt = MODE_STANDBY;
                        enter    = 1'b1;
                    end else if (btn_set) begin
                        mode_nxt = MODE_SET_REMIND;
                        enter    = 1'b1;
                    end
                end
                MODE_SET_REMIND: begin
                    if (btn_menu || btn_set) begin
                        mode_nxt = MODE_STANDBY;
                        enter    = 1'b1;
                    end
                end
                default: begin
                    // OFF, DRAIN and CLEAN respond only to long press and expiry.
                end
            endcase
        end

        // Fan level follows the target mode; only EXTRACT keeps a chosen level.
        case (mode_nxt)
            MODE_HURRICANE, MODE_DRAIN: fan_nxt = 2'd3;
            MODE_EXTRACT:               fan_nxt = fan_nxt;
            default:                    fan_nxt = 2'd0;
        endcase

        // Timed modes load on entry; otherwise count down once per second.
        if (enter) begin
            case (mode_nxt)
                MODE_HURRICANE, MODE_DRAIN: cd_nxt = CD_HURR;
                MODE_CLEAN:                 cd_nxt = CD_CLEAN;
                default:                    cd_nxt = '0;
            endcase
        end else if (sub_wrap && (countdown != '0)) begin
            cd_nxt = countdown - CD_W'(1);
        end

        pon_nxt = (mode_nxt != MODE_OFF);

        case (mode_nxt)
            MODE_EXTRACT, MODE_HURRICANE, MODE_DRAIN: state_nxt = ST_WORK;
            MODE_CLEAN:                               state_nxt = ST_CLEAN;
            default:                                  state_nxt = ST_IDLE;
        endcase

        case (mode_nxt)
            MODE_SET_TIME:   sat_nxt = SAT_TIME;
            MODE_SET_REMIND: sat_nxt = SAT_REMIND;
            default:         sat_nxt = SAT_NONE;
        endcase
    end

    // Mode register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode          <= MODE_OFF;
            power_on      <= 1'b0;
            state         <= ST_IDLE;
            set_all_times <= SAT_NONE;
            fan_level     <= 2'd0;
            countdown     <= '0;
        end else begin
            mode          <= mode_nxt;
            power_on      <= pon_nxt;
            state         <= state_nxt;
            set_all_times <= sat_nxt;
            fan_level     <= fan_nxt;
            countdown     <= cd_nxt;
        end
    end

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Bench for hood_mode_ctrl. It uses small timing parameters:
// 4 ticks per second, a 2 s long press, a 3 s hurricane/drain and a 5 s clean.
// The expected mode depends on whether HOOD_HURRICANE_LOCK_EN is defined.

module tb_hood_mode_ctrl;

    typedef struct packed {
        logic [2:0] mode;
        logic       pon;
        logic [1:0] st;
        logic [1:0] sat;
        logic [1:0] fan;
        logic [7:0] cd;
    } out_t;

    typedef struct {
        string      name;
        logic       pwr;
        logic [5:0] btn;
        int         ticks;
        out_t       exp;
    } vec_t;

`ifdef HOOD_HURRICANE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    // Button bit positions: {menu, l1, l2, l3, clean, set}
    localparam logic [5:0] B_NONE  = 6'b000000;
    localparam logic [5:0] B_MENU  = 6'b100000;
    localparam logic [5:0] B_L1    = 6'b010000;
    localparam logic [5:0] B_L2    = 6'b001000;
    localparam logic [5:0] B_L3    = 6'b000100;
    localparam logic [5:0] B_CLEAN = 6'b000010;
    localparam logic [5:0] B_SET   = 6'b000001;

    localparam logic [2:0] M_OFF = 3'd0, M_SB = 3'd1, M_EX = 3'd2, M_HU = 3'd3;
    localparam logic [2:0] M_DR = 3'd4, M_CL = 3'd5, M_ST = 3'd6, M_SR = 3'd7;

    logic       clk;
    logic       reset;
    logic       tick_100hz;
    logic       btn_power;
    logic       btn_menu, btn_l1, btn_l2, btn_l3, btn_clean, btn_set;
    logic       power_on;
    logic [1:0] state;
    logic [1:0] set_all_times;
    logic [1:0] fan_level;
    logic [2:0] mode;
    logic [7:0] countdown;

    int   tests_run;
    int   tests_failed;
    out_t exp_q[$];
    vec_t tbl[$];

    hood_mode_ctrl #(
        .TICK_HZ     (4),
        .LONG_PRESS_S(2),
        .HURRICANE_S (3),
        .CLEAN_S     (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_100hz   (tick_100hz),
        .btn_power    (btn_power),
        .btn_menu     (btn_menu),
        .btn_l1       (btn_l1),
        .btn_l2       (btn_l2),
        .btn_l3       (btn_l3),
        .btn_clean    (btn_clean),
        .btn_set      (btn_set),
        .power_on     (power_on),
        .state        (state),
        .set_all_times(set_all_times),
        .fan_level    (fan_level),
        .mode         (mode),
        .countdown    (countdown)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic out_t eo(logic [2:0] m, logic pon, logic [1:0] st,
                                logic [1:0] sat, logic [1:0] fan, logic [7:0] cd);
        out_t o;
        o.mode = m; o.pon = pon; o.st = st; o.sat = sat; o.fan = fan; o.cd = cd;
        return o;
    endfunction

    function automatic vec_t mk(string name, logic pwr, logic [5:0] btn, int ticks, out_t exp);
        vec_t v;
        v.name = name; v.pwr = pwr; v.btn = btn; v.ticks = ticks; v.exp = exp;
        return v;
    endfunction

    // Expected outputs for common resting states.
    function automatic out_t o_off();
        return eo(M_OFF, 1'b0, 2'b00, 2'b00, 2'd0, 8'd0);
    endfunction
    function automatic out_t o_sb();
        return eo(M_SB, 1'b1, 2'b00, 2'b00, 2'd0, 8'd0);
    endfunction

    task automatic check(string name);
        out_t got;
        out_t exp;
        got = {mode, power_on, state, set_all_times, fan_level, countdown};
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: scoreboard empty, got mode=%0d", name, got.mode);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s: got mode=%0d pon=%0d state=%b sat=%b fan=%0d cd=%0d, expected mode=%0d pon=%0d state=%b sat=%b fan=%0d cd=%0d",
                         name, got.mode, got.pon, got.st, got.sat, got.fan, got.cd,
                         exp.mode, exp.pon, exp.st, exp.sat, exp.fan, exp.cd);
            end
        end
    endtask

    // A button cycle with no tick, then 'ticks' tick cycles, then one quiet cycle; then compare.
    task automatic step(vec_t v);
        exp_q.push_back(v.exp);
        btn_power  = v.pwr;
        {btn_menu, btn_l1, btn_l2, btn_l3, btn_clean, btn_set} = v.btn;
        tick_100hz = 1'b0;
        @(posedge clk); #1;
        {btn_menu, btn_l1, btn_l2, btn_l3, btn_clean, btn_set} = B_NONE;
        for (int i = 0; i < v.ticks; i++) begin
            tick_100hz = 1'b1;
            @(posedge clk); #1;
        end
        tick_100hz = 1'b0;
        @(posedge clk); #1;
        check(v.name);
    endtask

    task automatic power_cycle(string name);
        step(mk({name, "_off"},     1'b1, B_NONE, 8, o_off()));
        step(mk({name, "_rel1"},    1'b0, B_NONE, 0, o_off()));
        step(mk({name, "_on"},      1'b1, B_NONE, 8, o_sb()));
        step(mk({name, "_rel2"},    1'b0, B_NONE, 0, o_sb()));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        tick_100hz   = 1'b0;
        btn_power    = 1'b0;
        {btn_menu, btn_l1, btn_l2, btn_l3, btn_clean, btn_set} = B_NONE;

        tbl.push_back(mk("lp_on",        1'b1, B_NONE,  8, o_sb()));
        tbl.push_back(mk("lp_hold",      1'b1, B_NONE, 20, o_sb()));
        tbl.push_back(mk("lp_release",   1'b0, B_NONE,  0, o_sb()));
        tbl.push_back(mk("lp_off",       1'b1, B_NONE,  8, o_off()));
        tbl.push_back(mk("off_release",  1'b0, B_NONE,  0, o_off()));
        tbl.push_back(mk("off_ignore",   1'b0, B_L1 | B_SET | B_CLEAN, 0, o_off()));
        tbl.push_back(mk("lp_on2",       1'b1, B_NONE,  8, o_sb()));
        tbl.push_back(mk("on2_release",  1'b0, B_NONE,  0, o_sb()));
        tbl.push_back(mk("hurr_entry",   1'b0, B_L3,    0, eo(M_HU, 1'b1, 2'b10, 2'b00, 2'd3, 8'd3)));
        tbl.push_back(mk("hurr_1s",      1'b0, B_NONE,  4, eo(M_HU, 1'b1, 2'b10, 2'b00, 2'd3, 8'd2)));
        tbl.push_back(mk("hurr_expire",  1'b0, B_NONE,  8, eo(M_EX, 1'b1, 2'b10, 2'b00, 2'd2, 8'd0)));
        tbl.push_back(mk("ex_l1",        1'b0, B_L1,    0, eo(M_EX, 1'b1, 2'b10, 2'b00, 2'd1, 8'd0)));
        tbl.push_back(mk("ex_l3_ign",    1'b0, B_L3,    0, eo(M_EX, 1'b1, 2'b10, 2'b00, 2'd1, 8'd0)));
        tbl.push_back(mk("ex_menu_l2",   1'b0, B_MENU | B_L2, 0, o_sb()));
        tbl.push_back(mk("clean_entry",  1'b0, B_CLEAN, 0, eo(M_CL, 1'b1, 2'b11, 2'b00, 2'd0, 8'd5)));
        tbl.push_back(mk("clean_ignore", 1'b0, B_MENU | B_L1, 0, eo(M_CL, 1'b1, 2'b11, 2'b00, 2'd0, 8'd5)));
        tbl.push_back(mk("clean_expire", 1'b0, B_NONE, 20, o_sb()));
        tbl.push_back(mk("set_time",     1'b0, B_SET,   0, eo(M_ST, 1'b1, 2'b00, 2'b01, 2'd0, 8'd0)));
        tbl.push_back(mk("set_remind",   1'b0, B_SET,   0, eo(M_SR, 1'b1, 2'b00, 2'b10, 2'd0, 8'd0)));
        tbl.push_back(mk("set_exit",     1'b0, B_SET,   0, o_sb()));
        tbl.push_back(mk("set_time2",    1'b0, B_SET,   0, eo(M_ST, 1'b1, 2'b00, 2'b01, 2'd0, 8'd0)));
        tbl.push_back(mk("set_menu",     1'b0, B_MENU,  0, o_sb()));
        tbl.push_back(mk("sb_l2_over_l1", 1'b0, B_L2 | B_L1, 0, eo(M_EX, 1'b1, 2'b10, 2'b00, 2'd2, 8'd0)));
        tbl.push_back(mk("ex_menu",      1'b0, B_MENU,  0, o_sb()));
        tbl.push_back(mk("sb_clean_prio", 1'b0, B_CLEAN | B_SET | B_L3, 0, eo(M_CL, 1'b1, 2'b11, 2'b00, 2'd0, 8'd5)));
        tbl.push_back(mk("clean_done2",  1'b0, B_NONE, 20, o_sb()));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(o_off());
        check("reset_state");
        reset = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // Drain behaviour and hurricane lock
        power_cycle("pc1");
        step(mk("h_entry",     1'b0, B_L3,   0, eo(M_HU, 1'b1, 2'b10, 2'b00, 2'd3, 8'd3)));
        step(mk("h_5ticks",    1'b0, B_NONE, 5, eo(M_HU, 1'b1, 2'b10, 2'b00, 2'd3, 8'd2)));
        step(mk("drain_entry", 1'b0, B_MENU, 0, eo(M_DR, 1'b1, 2'b10, 2'b00, 2'd3, 8'd3)));
        step(mk("drain_ign",   1'b0, B_L1 | B_L2 | B_MENU, 0, eo(M_DR, 1'b1, 2'b10, 2'b00, 2'd3, 8'd3)));
        step(mk("drain_done",  1'b0, B_NONE, 12, o_sb()));
        step(mk("lock_l3",     1'b0, B_L3,   0,
                LOCK ? o_sb() : eo(M_HU, 1'b1, 2'b10, 2'b00, 2'd3, 8'd3)));
        step(mk("lock_menu",   1'b0, B_MENU, 0,
                LOCK ? o_sb() : eo(M_DR, 1'b1, 2'b10, 2'b00, 2'd3, 8'd3)));
        step(mk("lock_settle", 1'b0, B_NONE, 12, o_sb()));
        power_cycle("pc2");
        step(mk("unlock_l3",   1'b0, B_L3,   0, eo(M_HU, 1'b1, 2'b10, 2'b00, 2'd3, 8'd3)));
        step(mk("unlock_menu", 1'b0, B_MENU, 0, eo(M_DR, 1'b1, 2'b10, 2'b00, 2'd3, 8'd3)));
        step(mk("unlock_done", 1'b0, B_NONE, 12, o_sb()));

        // Reset in the middle of CLEAN with countdown 2
        step(mk("rc_clean",    1'b0, B_CLEAN, 0, eo(M_CL, 1'b1, 2'b11, 2'b00, 2'd0, 8'd5)));
        step(mk("rc_cd2",      1'b0, B_NONE, 12, eo(M_CL, 1'b1, 2'b11, 2'b00, 2'd0, 8'd2)));
        reset = 1'b0;
        tick_100hz = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(o_off());
        check("rc_reset");
        reset = 1'b1;
        tick_100hz = 1'b0;
        step(mk("rc_after",    1'b0, B_CLEAN | B_L1, 4, o_off()));

        // Reset in the middle of a long press restarts the hold count
        step(mk("rl_hold5",    1'b1, B_NONE, 5, o_off()));
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        step(mk("rl_hold5b",   1'b1, B_NONE, 5, o_off()));
        step(mk("rl_hold3",    1'b1, B_NONE, 3, o_sb()));
        step(mk("rl_release",  1'b0, B_NONE, 0, o_sb()));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hood_mode_ctrl.md
# hood_mode_ctrl

Mode sequencer for the range-hood controller. It turns debounced front-panel inputs into the system operating mode and drives the control inputs of the timekeeping/work-time block: `power_on`, `state` and `set_all_times`. It also drives the fan level and a seconds countdown for the display. It sits between the button debouncers and the timekeeping, fan and display logic.

## Interface
- `TICK_HZ`, 100, `tick_100hz` pulses per second
- `LONG_PRESS_S`, 3, seconds `btn_power` must be held to toggle power
- `HURRICANE_S`, 60, level-3 run time, and also the post-menu drain time
- `CLEAN_S`, 180, self-clean duration in seconds
- `clk` in 1: system clock; all logic on its rising edge
- `reset` in 1: synchronous, active-low reset
- `tick_100hz` in 1: single-cycle enable at `TICK_HZ` rate
- `btn_power` in 1: debounced level, 1 = held
- `btn_menu`, `btn_l1`, `btn_l2`, `btn_l3`, `btn_clean`, `btn_set` in 1 each: debounced single-cycle press pulses
- `power_on` out 1: 1 in every mode except OFF
- `state` out 2: 00 idle (OFF/STANDBY/SET_*), 10 working (EXTRACT/HURRICANE/DRAIN), 11 cleaning
- `set_all_times` out 2: 01 in SET_TIME, 10 in SET_REMIND, else 00
- `fan_level` out 2: 0 off, 1, 2, 3 = hurricane
- `mode` out 3: OFF=0, STANDBY=1, EXTRACT=2, HURRICANE=3, DRAIN=4, CLEAN=5, SET_TIME=6, SET_REMIND=7
- `countdown` out 8: seconds remaining in a timed mode, else 0

## Operation
- Seconds base: `sub_cnt` counts `tick_100hz` from 0 to TICK_HZ-1. On the wrap it decrements `countdown` if that is nonzero. `sub_cnt` clears on every mode entry, so the first second is always a full second.
- Long press:
  - `lp_cnt` counts ticks while `btn_power`=1 and clears when it is 0.
  - When it reaches LONG_PRESS_S*TICK_HZ, a one-cycle `lp_evt` fires and `lp_done` latches.
  - No further event fires until `btn_power` is released.
- OFF: `lp_evt` moves to STANDBY. All other inputs are ignored.
- STANDBY:
  - `btn_l1` moves to EXTRACT at level 1.
  - `btn_l2` moves to EXTRACT at level 2.
  - `btn_l3` moves to HURRICANE, subject to the lock.
  - `btn_clean` moves to CLEAN.
  - `btn_set` moves to SET_TIME.
- EXTRACT: `btn_l1`/`btn_l2` change the level and stay in EXTRACT. `btn_menu` moves to STANDBY. `btn_l3` is ignored.
- HURRICANE:
  - On entry, `countdown` = HURRICANE_S and `fan_level` = 3.
  - When `countdown` reaches 0, move to EXTRACT at level 2.
  - `btn_menu` moves to DRAIN.
- DRAIN: `fan_level` = 3 and `countdown` reloads to HURRICANE_S. At 0, move to STANDBY. All buttons are ignored.
- CLEAN: `countdown` = CLEAN_S, `fan_level` = 0, `state` = 11. At 0, move to STANDBY. All buttons except long press are ignored.
- SET_TIME: `btn_set` moves to SET_REMIND. SET_REMIND: `btn_set` moves to STANDBY. `btn_menu` in either state moves to STANDBY.
- `lp_evt` in any non-OFF state moves to OFF. All outputs then take their reset values and the hurricane lock clears.
- Priority within one cycle, highest first:
  1. `lp_evt`
  2. countdown expiry
  3. `btn_menu`
  4. `btn_clean`
  5. `btn_l3`
  6. `btn_l2`
  7. `btn_l1`
  8. `btn_set`
- Only one transition happens per cycle.

## Timing
- Reset (`reset`=0 at a `clk` edge) gives:
  - mode OFF, `power_on`=0, `state`=00, `set_all_times`=00
  - `fan_level`=0, `countdown`=0
  - `sub_cnt`=0, `lp_cnt`=0, `lp_done`=0, lock clear
- All outputs are registered. A button pulse at edge N gives the new mode and outputs after edge N+1.
- Expiry: the tick that takes `countdown` from 1 to 0 causes the transition on the next edge. `countdown` never underflows.
- A reset asserted mid-countdown or mid-long-press abandons the operation immediately; no partial transition is kept.
- `lp_cnt` saturates at its threshold, so holding `btn_power` indefinitely never wraps the counter.
- Buttons arriving in a cycle without a tick are still honoured; ticks only affect the counters.

## Configuration
- `HOOD_HURRICANE_LOCK_EN` defined:
  - Entering HURRICANE sets a lock.
  - While the lock is set, `btn_l3` is ignored in STANDBY.
  - The lock clears only on power-off or reset.
- `HOOD_HURRICANE_LOCK_EN` undefined: `btn_l3` from STANDBY always enters HURRICANE, and no lock register exists.

## Test plan
Benches use TICK_HZ=4, LONG_PRESS_S=2, HURRICANE_S=3, CLEAN_S=5.
1. Hold `btn_power` for 8 ticks -> `power_on` rises one cycle after the 8th tick. Keep holding for 20 more ticks -> no second toggle. Release, then hold 8 ticks -> mode OFF, all outputs 0.
2. STANDBY, pulse `btn_l3` -> mode 3, `fan_level` 3, `state` 10, `countdown` 3. After 12 ticks -> EXTRACT, `fan_level` 2, `countdown` 0.
3. With LOCK_EN defined: HURRICANE, `btn_menu` -> DRAIN; after 12 ticks -> STANDBY. Pulse `btn_l3` -> stays STANDBY. Power-cycle, then `btn_l3` -> HURRICANE.
4. STANDBY, `btn_clean` -> `state` 11, `countdown` 5. Pulse `btn_menu` and `btn_l1` -> no effect. After 20 ticks -> STANDBY, `state` 00.
5. STANDBY, `btn_set` -> `set_all_times` 01. Second `btn_set` -> 10. Third `btn_set` -> 00 in STANDBY. Pulse `btn_menu` and `btn_l2` in the same cycle while in EXTRACT -> STANDBY (menu wins).
6. Reset asserted during CLEAN with `countdown` 2 -> next cycle all outputs are at reset values and mode is OFF.
